tmds_decoder: RTL and testbench
===============================

# tmds_decoder

Receive-side counterpart to the DVI transmit path: recovers one TMDS channel from raw 10-bit words delivered by a deserializer in the pixel clock domain. The block finds the 10-bit word boundary in software-free fashion by sliding a window over two consecutive input words until control tokens appear. It then decodes each aligned word to either a control pair (blanking) or an 8-bit pixel value (active video). One instance is used per channel; the channel 0 instance yields hsync/vsync.

## Interface
- CTRL_RUN, 8: consecutive control tokens required to declare alignment
- TIMEOUT, 4096: cycles without a qualifying token run before the window slides (must exceed one line period)
- clk_pix  input  1  pixel clock; all logic on rising edge
- rst_pix  input  1  synchronous, active-high reset
- din  input  10  raw deserialized word; bit 0 is earliest received
- de  output  1  1 = data period (aligned word is not a control token)
- ctrl  output  2  control value {c1,c0} of last control token
- data  output  8  decoded pixel value during de
- locked  output  1  word alignment established
- offset  output  4  current window offset, 0..9

## Operation
- Input history: din_prev registered each cycle; hist = {din, din_prev} (20 bits, earlier bits low).
- Alignment window: aligned = hist[offset+9 : offset], registered each cycle.
- Control tokens (aligned value -> ctrl): 0x354 -> 00, 0x0AB -> 01, 0x154 -> 10, 0x2AB -> 11.
- Run counter: increments on each aligned control token, clears on any non-token, saturates at CTRL_RUN; "run complete" is the cycle it reaches CTRL_RUN from CTRL_RUN-1 (once per blanking run).
- Timeout counter: increments every cycle, cleared on run complete and on every slip.
- States: SEARCH (reset state), LOCKED.
  - SEARCH: run complete -> LOCKED. Timeout counter = TIMEOUT-1 -> slip.
  - LOCKED: run complete -> stay, clear timeout. Timeout counter = TIMEOUT-1 -> slip and enter SEARCH.
  - Slip: offset <= (offset==9) ? 0 : offset+1; run and timeout counters clear.
  - Run complete and timeout in same cycle: run complete wins, no slip.
- Decode (from aligned word q, registered to outputs):
  - Token: de=0, ctrl=token value, data=0.
  - Otherwise: de=1, ctrl holds previous value; qm = q[9] ? ~q[7:0] : q[7:0]; data[0]=qm[0]; data[i] = q[8] ? qm[i]^qm[i-1] : ~(qm[i]^qm[i-1]), i=1..7.
- While locked=0: de=0, data=0, ctrl=0 are forced; run/timeout tracking continues.
- locked = (state==LOCKED), registered.

## Timing
- Reset: state SEARCH, offset 0, din_prev 0, aligned 0, counters 0, de 0, ctrl 00, data 0, locked 0. Reset asserted mid-operation returns to this state on the next edge, discarding alignment.
- Latency: word whose final bit arrives in din at edge N appears on de/ctrl/data after edge N+2.
- locked rises the cycle after run complete is evaluated on the aligned register, i.e. CTRL_RUN+2 edges after the first token word enters din (offset already correct).
- Slip takes effect on the next edge; the aligned word formed from the new offset is valid one edge later. Tokens straddling the slip are not counted (counters cleared).
- Worst-case acquisition from reset: 10 x TIMEOUT cycles plus one run.
- Lock loss: locked falls on the edge after timeout expiry; outputs forced idle from that edge.
- No backpressure; one word in, one word out per cycle.

## Test plan
- Reset, then offset-0 stream of 20 x 0x354 -> locked=1 after 10 edges, offset=0, de=0, ctrl=00; reassert rst_pix -> all outputs 0 next edge.
- Stream of 0x2AB tokens shifted by 3 bits (TIMEOUT=64) -> offset steps 0,1,2,3 at 64-cycle intervals, locks at offset 3, ctrl=11.
- Locked, feed 0x100, 0x3FF, 0x0FF, 0x2FF -> de=1, data 0x00, 0x00, 0xFF, 0xFE two cycles later; ctrl holds last token value.
- Locked, data-only for TIMEOUT cycles -> locked falls, offset 0->1, de forced 0.
- Locked at offset 9 with timeout expiry -> offset wraps to 0; run complete coinciding with timeout expiry -> no slip, lock held.
- Runs of CTRL_RUN-1 tokens separated by a data word -> never locks; exactly CTRL_RUN -> locks.

Source files
------------

// File: rtl/tmds_decoder.sv
// TMDS receive channel: finds the 10-bit word boundary by sliding a window over two
// consecutive deserialized words, then decodes aligned words to control tokens or pixels.
module tmds_decoder #(
  parameter int unsigned CTRL_RUN = 8,
  parameter int unsigned TIMEOUT  = 4096
) (
  input  logic       clk_pix,
  input  logic       rst_pix,
  input  logic [9:0] din,
  output logic       de,
  output logic [1:0] ctrl,
  output logic [7:0] data,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int unsigned RunW = $clog2(CTRL_RUN + 1);
  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [0:0] StSearch = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  logic [9:0]      din_prev_q;
  logic [9:0]      aligned_q, aligned_d;
  logic [19:0]     hist, hist_sh;
  logic [RunW-1:0] run_q, run_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [0:0]      state_q, state_d;
  logic [3:0]      offset_q, offset_d;
  logic            de_q, de_d;
  logic [1:0]      ctrl_q, ctrl_d;
  logic [7:0]      data_q, data_d;
  logic            locked_q, lock_d;

  logic            is_tok;
  logic [1:0]      tok_val;
  logic            run_done;
  logic            tmo_exp;
  logic            slip;
  logic [7:0]      qm;
  logic [7:0]      pix;

  // Earlier bits sit low, so offset 0 selects the previous word intact.
  assign hist      = {din, din_prev_q};
  assign hist_sh   = hist >> offset_q;
  assign aligned_d = hist_sh[9:0];

  always_comb begin
    is_tok  = 1'b1;
    tok_val = 2'b00;
    case (aligned_q)
      10'h354: tok_val = 2'b00;
      10'h0AB: tok_val = 2'b01;
      10'h154: tok_val = 2'b10;
      10'h2AB: tok_val = 2'b11;
      default: is_tok = 1'b0;
    endcase
  end

  assign run_done = is_tok && (run_q == RunW'(CTRL_RUN - 1));
  assign tmo_exp  = (tmo_q == TmoW'(TIMEOUT - 1));
  // A completed run proves the current offset, so it overrides an expiring timeout.
  assign slip     = tmo_exp && !run_done;

  always_comb begin
    run_d = run_q;
    if (slip || !is_tok) begin
      run_d = '0;
    end else if (run_q != RunW'(CTRL_RUN)) begin
      run_d = run_q + 1'b1;
    end
  end

  always_comb begin
    tmo_d    = (slip || run_done) ? '0 : tmo_q + 1'b1;
    offset_d = offset_q;
    if (slip) begin
      offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
    end
    state_d = state_q;
    if (run_done) begin
      state_d = StLocked;
    end else if (slip) begin
      state_d = StSearch;
    end
  end

  always_comb begin
    qm     = aligned_q[9] ? ~aligned_q[7:0] : aligned_q[7:0];
    pix    = '0;
    pix[0] = qm[0];
    for (int i = 1; i < 8; i++) begin
      pix[i] = aligned_q[8] ? (qm[i] ^ qm[i-1]) : ~(qm[i] ^ qm[i-1]);
    end
  end

  // Outputs follow the next lock state so they go idle on the same edge locked falls.
  always_comb begin
    lock_d = (state_d == StLocked);
    de_d   = lock_d && !is_tok;
    ctrl_d = ctrl_q;
    data_d = '0;
    if (!lock_d) begin
      ctrl_d = 2'b00;
    end else if (is_tok) begin
      ctrl_d = tok_val;
    end else begin
      data_d = pix;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      din_prev_q <= '0;
      aligned_q  <= '0;
      run_q      <= '0;
      tmo_q      <= '0;
      state_q    <= StSearch;
      offset_q   <= '0;
      de_q       <= 1'b0;
      ctrl_q     <= 2'b00;
      data_q     <= '0;
      locked_q   <= 1'b0;
    end else begin
      din_prev_q <= din;
      aligned_q  <= aligned_d;
      run_q      <= run_d;
      tmo_q      <= tmo_d;
      state_q    <= state_d;
      offset_q   <= offset_d;
      de_q       <= de_d;
      ctrl_q     <= ctrl_d;
      data_q     <= data_d;
      locked_q   <= lock_d;
    end
  end

  assign de     = de_q;
  assign ctrl   = ctrl_q;
  assign data   = data_q;
  assign locked = locked_q;
  assign offset = offset_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: lock acquisition, window slips, decode and lock loss.
module tb_tmds_decoder;

  localparam int unsigned CtrlRun = 8;
  localparam int unsigned Timeout = 64;

  logic       clk_pix = 1'b0;
  logic       rst_pix;
  logic [9:0] din;
  logic       de;
  logic [1:0] ctrl;
  logic [7:0] data;
  logic       locked;
  logic [3:0] offset;

  int n_checks;
  int n_fail;
  int cyc;

  always #5 clk_pix = ~clk_pix;

  tmds_decoder #(
    .CTRL_RUN(CtrlRun),
    .TIMEOUT (Timeout)
  ) dut (
    .clk_pix(clk_pix),
    .rst_pix(rst_pix),
    .din    (din),
    .de     (de),
    .ctrl   (ctrl),
    .data   (data),
    .locked (locked),
    .offset (offset)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_pix);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  // Two reset edges, then release with the given word already on din; edge count restarts.
  task automatic reset_to(input logic [9:0] word);
    rst_pix = 1'b1;
    din     = '0;
    step();
    step();
    check_eq("rst_locked", 16'(locked), 16'd0);
    check_eq("rst_offset", 16'(offset), 16'd0);
    check_eq("rst_ctrl", 16'(ctrl), 16'd0);
    rst_pix = 1'b0;
    din     = word;
    cyc     = 0;
  endtask

  function automatic logic [9:0] rotl(input logic [9:0] w, input int unsigned s);
    logic [19:0] d;
    d = {w, w} << s;
    return d[19:10];
  endfunction

  logic [9:0] words  [6] = '{10'h100, 10'h3FF, 10'h0FF, 10'h2FF, 10'h354, 10'h0FF};
  logic       exp_de [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [7:0] exp_dat[6] = '{8'h00, 8'h00, 8'hFF, 8'hFE, 8'h00, 8'hFF};
  logic [1:0] exp_ctl[6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst_pix  = 1'b1;
    din      = '0;

    // Offset-0 token stream locks after exactly CTRL_RUN+2 edges.
    reset_to(10'h354);
    step_to(9);
    check_eq("t1_locked_early", 16'(locked), 16'd0);
    step_to(10);
    check_eq("t1_locked", 16'(locked), 16'd1);
    check_eq("t1_offset", 16'(offset), 16'd0);
    check_eq("t1_de", 16'(de), 16'd0);
    check_eq("t1_ctrl", 16'(ctrl), 16'd0);
    step_to(20);
    rst_pix = 1'b1;
    step();
    check_eq("t1_rst_locked", 16'(locked), 16'd0);
    check_eq("t1_rst_de", 16'(de), 16'd0);
    check_eq("t1_rst_data", 16'(data), 16'd0);

    // Tokens shifted by 3 bits: one slip per timeout until offset 3 matches.
    reset_to(rotl(10'h2AB, 3));
    step_to(63);
    check_eq("t2_off_63", 16'(offset), 16'd0);
    step_to(64);
    check_eq("t2_off_64", 16'(offset), 16'd1);
    step_to(127);
    check_eq("t2_off_127", 16'(offset), 16'd1);
    step_to(128);
    check_eq("t2_off_128", 16'(offset), 16'd2);
    step_to(192);
    check_eq("t2_off_192", 16'(offset), 16'd3);
    step_to(200);
    check_eq("t2_locked_early", 16'(locked), 16'd0);
    step_to(201);
    check_eq("t2_locked", 16'(locked), 16'd1);
    check_eq("t2_offset", 16'(offset), 16'd3);
    check_eq("t2_ctrl", 16'(ctrl), 16'd3);
    check_eq("t2_de", 16'(de), 16'd0);

    // Decode of data words with two-edge latency, then lock loss on timeout.
    reset_to(10'h154);
    step_to(10);
    check_eq("t3_locked", 16'(locked), 16'd1);
    check_eq("t3_ctrl", 16'(ctrl), 16'd2);
    for (int i = 0; i < 8; i++) begin
      din = (i < 6) ? words[i] : 10'h0FF;
      step();
      if (i >= 2) begin
        check_eq($sformatf("t3_de_%0d", i - 2), 16'(de), 16'(exp_de[i-2]));
        check_eq($sformatf("t3_data_%0d", i - 2), 16'(data), 16'(exp_dat[i-2]));
        check_eq($sformatf("t3_ctrl_%0d", i - 2), 16'(ctrl), 16'(exp_ctl[i-2]));
      end
    end
    din = 10'h0FF;
    step_to(73);
    check_eq("t4_locked_held", 16'(locked), 16'd1);
    check_eq("t4_de_held", 16'(de), 16'd1);
    check_eq("t4_data_held", 16'(data), 16'hFF);
    check_eq("t4_off_held", 16'(offset), 16'd0);
    step_to(74);
    check_eq("t4_locked_lost", 16'(locked), 16'd0);
    check_eq("t4_offset_slip", 16'(offset), 16'd1);
    check_eq("t4_de_forced", 16'(de), 16'd0);
    check_eq("t4_data_forced", 16'(data), 16'd0);

    // Lock at offset 9, then timeout wraps the window back to 0.
    reset_to(rotl(10'h2AB, 9));
    step_to(575);
    check_eq("t5_off_575", 16'(offset), 16'd8);
    step_to(576);
    check_eq("t5_off_576", 16'(offset), 16'd9);
    step_to(584);
    check_eq("t5_locked_early", 16'(locked), 16'd0);
    step_to(585);
    check_eq("t5_locked", 16'(locked), 16'd1);
    step_to(648);
    check_eq("t5_locked_held", 16'(locked), 16'd1);
    step_to(649);
    check_eq("t5_off_wrap", 16'(offset), 16'd0);
    check_eq("t5_locked_lost", 16'(locked), 16'd0);

    // Run completes on the very cycle the timeout expires: no slip.
    reset_to(10'h354);
    step_to(10);
    din = 10'h100;
    step_to(64);
    din = 10'h354;
    step_to(72);
    din = 10'h100;
    step_to(74);
    check_eq("t5b_locked", 16'(locked), 16'd1);
    check_eq("t5b_offset", 16'(offset), 16'd0);
    step_to(137);
    check_eq("t5b_locked_137", 16'(locked), 16'd1);
    step_to(138);
    check_eq("t5b_locked_138", 16'(locked), 16'd0);
    check_eq("t5b_offset_138", 16'(offset), 16'd1);

    // Runs one short of CTRL_RUN never lock; a full run does.
    reset_to(10'h354);
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 8; k++) begin
        din = (k < 7) ? 10'h354 : 10'h100;
        step();
      end
      check_eq($sformatf("t6_short_%0d", g), 16'(locked), 16'd0);
    end
    din = 10'h0AB;
    step_to(40);
    din = 10'h100;
    step_to(41);
    check_eq("t6_full_early", 16'(locked), 16'd0);
    step_to(42);
    check_eq("t6_full_locked", 16'(locked), 16'd1);
    check_eq("t6_full_ctrl", 16'(ctrl), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
